cnn_frame_bist: RTL and testbench

// Synthesizable self-test sequencer for CNN_TOP. Issues start pulses, streams generated

---
 rtl/cnn_bist_pkg.sv | 28 ++
 rtl/cnn_pattern_gen.sv | 71 +++++++
 rtl/cnn_frame_bist.sv | 210 +++++++++++++++++++++
 tb/tb_cnn_frame_bist.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_bist_pkg.sv
// Shared types and helpers for the CNN frame self-test sequencer.
// Holds the FSM and pattern-mode enums, plus the LFSR step used by the pattern generator.
package cnn_bist_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        STREAM   = 3'd2,
        WAIT_RES = 3'd3,
        CHECK    = 3'd4,
        DONE     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        MODE_RAMP    = 2'd0,
        MODE_CONST   = 2'd1,
        MODE_LFSR    = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_t;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/cnn_pattern_gen.sv
// Row-major pixel pattern source: x/y/index counters, LFSR and the pattern mux.
// The pixel output always shows the pixel at the current index; advance steps to the next one.
module cnn_pattern_gen
    import cnn_bist_pkg::*;
#(
    parameter int          IMG_W     = 32,
    parameter int          IMG_H     = 32,
    parameter int          PIX_W     = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_init,
    input  logic             advance,
    input  mode_t            mode,
    input  logic [PIX_W-1:0] const_val,
    output logic [PIX_W-1:0] pixel,
    output logic             row_end,
    output logic             last_pix
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int IDX_W = $clog2(NPIX + 1);
    localparam int X_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int Y_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_lfsr;
    logic             w_chk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_idx  <= '0;
            r_lfsr <= LFSR_SEED;
        end else if (frame_init) begin
            r_x    <= '0;
            r_y    <= '0;
            r_idx  <= '0;
            r_lfsr <= LFSR_SEED;
        end else if (advance) begin
            r_idx  <= r_idx + 1'b1;
            r_lfsr <= lfsr_next(r_lfsr);
            if (row_end) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign row_end  = (r_x == X_W'(IMG_W - 1));
    assign last_pix = (r_idx == IDX_W'(NPIX - 1));
    assign w_chk    = r_x[0] ^ r_y[0];

    always_comb begin
        pixel = '0;
        case (mode)
            MODE_RAMP:    pixel = PIX_W'(r_idx);
            MODE_CONST:   pixel = const_val;
            MODE_LFSR:    pixel = PIX_W'(r_lfsr);
            MODE_CHECKER: pixel = {PIX_W{w_chk}};
            default:      pixel = '0;
        endcase
    end

endmodule

// File: rtl/cnn_frame_bist.sv
// Self-test sequencer for CNN_TOP: starts the engine, streams generated frames, waits for
// each result (with timeout), compares it against the expected value and keeps run status.
module cnn_frame_bist
    import cnn_bist_pkg::*;
#(
    parameter int          IMG_W     = 32,
    parameter int          IMG_H     = 32,
    parameter int          PIX_W     = 8,
    parameter int          RES_W     = 48,
    parameter int          TIMEOUT   = 4096,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bist_start,
    input  logic [1:0]              mode,
    input  logic [PIX_W-1:0]        const_val,
    input  logic [7:0]              num_frames,
    input  logic                    gap_en,
    input  logic signed [RES_W-1:0] expected,
    output logic                    start_signal,
    output logic                    pixel_valid,
    output logic [PIX_W-1:0]        pixel_in,
    input  logic                    final_result_valid,
    input  logic signed [RES_W-1:0] final_lane_result,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [7:0]              frame_cnt,
    output logic [7:0]              mismatch_cnt,
    output logic                    err_timeout,
    output logic                    err_spurious,
    output logic signed [RES_W-1:0] last_result,
    output state_t                  dbg_state
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    // All CNN-side links are one-way strobes with no back-pressure: a beat exists exactly in
    // the cycle pixel_valid is high, and a result exists exactly in the cycle final_result_valid is high.
    state_t                  r_state;
    logic                    r_start_signal;
    logic                    r_pixel_valid;
    logic [PIX_W-1:0]        r_pixel_in;
    logic                    r_busy;
    logic                    r_done;
    logic [7:0]              r_frame_cnt;
    logic [7:0]              r_mismatch_cnt;
    logic                    r_err_timeout;
    logic                    r_err_spurious;
    logic signed [RES_W-1:0] r_last_result;
    mode_t                   r_mode;
    logic                    r_gap;
    logic [7:0]              r_num_frames;
    logic                    r_row_q;
    logic                    r_last_q;
    logic [TO_W-1:0]         r_to_cnt;
    logic                    r_timed_out;

    logic                    w_accept;
    logic                    w_gap_need;
    logic                    w_stream_done;
    logic                    w_emit;
    logic                    w_frame_init;
    logic [7:0]              w_frames_eff;
    logic                    w_frame_last;
    logic                    w_mismatch;
    logic                    w_to_hit;
    logic [PIX_W-1:0]        w_pixel;
    logic                    w_row_end;
    logic                    w_last_pix;

    assign w_accept      = bist_start && (r_state == IDLE || r_state == DONE);
    // r_row_q/r_last_q describe the beat currently on the bus (or the one before a gap)
    assign w_gap_need    = r_pixel_valid && r_row_q && r_gap;
    assign w_stream_done = r_last_q && (!r_pixel_valid || !r_gap);
    assign w_emit        = (r_state == START) ||
                           (r_state == STREAM && !w_stream_done && !w_gap_need);
    assign w_frame_init  = w_accept || (r_state == CHECK);
    assign w_frames_eff  = (r_num_frames == 8'd0) ? 8'd1 : r_num_frames;
    assign w_frame_last  = ({1'b0, r_frame_cnt} + 9'd1) >= {1'b0, w_frames_eff};
    assign w_mismatch    = r_timed_out || (r_last_result != expected);
    assign w_to_hit      = (r_to_cnt == TO_W'(TIMEOUT - 1));

    cnn_pattern_gen #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .PIX_W     (PIX_W),
        .LFSR_SEED (LFSR_SEED)
    ) u_pattern (
        .clk        (clk),
        .rst        (rst),
        .frame_init (w_frame_init),
        .advance    (w_emit),
        .mode       (r_mode),
        .const_val  (const_val),
        .pixel      (w_pixel),
        .row_end    (w_row_end),
        .last_pix   (w_last_pix)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_start_signal <= 1'b0;
            r_pixel_valid  <= 1'b0;
            r_pixel_in     <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_frame_cnt    <= '0;
            r_mismatch_cnt <= '0;
            r_err_timeout  <= 1'b0;
            r_err_spurious <= 1'b0;
            r_last_result  <= '0;
            r_mode         <= MODE_RAMP;
            r_gap          <= 1'b0;
            r_num_frames   <= '0;
            r_row_q        <= 1'b0;
            r_last_q       <= 1'b0;
            r_to_cnt       <= '0;
            r_timed_out    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bist_start) begin
                        r_state        <= START;
                        r_start_signal <= 1'b1;
                        r_busy         <= 1'b1;
                        r_done         <= 1'b0;
                        r_frame_cnt    <= '0;
                        r_mismatch_cnt <= '0;
                        r_err_timeout  <= 1'b0;
                        r_err_spurious <= 1'b0;
                        r_timed_out    <= 1'b0;
                        r_mode         <= mode_t'(mode);
                        r_gap          <= gap_en;
                        r_num_frames   <= num_frames;
                    end
                end
                START: begin
                    r_start_signal <= 1'b0;
                    r_state        <= STREAM;
                end
                STREAM: begin
                    if (w_stream_done) begin
                        r_state     <= WAIT_RES;
                        r_to_cnt    <= '0;
                        r_timed_out <= 1'b0;
                    end
                end
                WAIT_RES: begin
                    // A result arriving in the timeout cycle still counts as a real answer
                    if (final_result_valid) begin
                        r_last_result <= final_lane_result;
                        r_state       <= CHECK;
                    end else if (w_to_hit) begin
                        r_err_timeout <= 1'b1;
                        r_timed_out   <= 1'b1;
                        r_state       <= CHECK;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (w_mismatch && r_mismatch_cnt != 8'hFF) begin
                        r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
                    end
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                    r_timed_out <= 1'b0;
                    if (w_frame_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state        <= START;
                        r_start_signal <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_emit) begin
                r_pixel_valid <= 1'b1;
                r_pixel_in    <= w_pixel;
                r_row_q       <= w_row_end;
                r_last_q      <= w_last_pix;
            end else begin
                r_pixel_valid <= 1'b0;
            end

            if (final_result_valid && r_state != WAIT_RES && !w_accept) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

    assign start_signal = r_start_signal;
    assign pixel_valid  = r_pixel_valid;
    assign pixel_in     = r_pixel_in;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_done && (r_mismatch_cnt == 8'd0) && !r_err_timeout && !r_err_spurious;
    assign frame_cnt    = r_frame_cnt;
    assign mismatch_cnt = r_mismatch_cnt;
    assign err_timeout  = r_err_timeout;
    assign err_spurious = r_err_spurious;
    assign last_result  = r_last_result;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_cnn_frame_bist.sv
// Bench for cnn_frame_bist: behavioural CNN responder, pixel scoreboard, run table and
// hand-written sequences for gaps, timeout, spurious results and mid-run reset.
module tb_cnn_frame_bist;
    import cnn_bist_pkg::*;

    localparam int IMG_W   = 32;
    localparam int IMG_H   = 32;
    localparam int PIX_W   = 8;
    localparam int RES_W   = 48;
    localparam int TIMEOUT = 4096;
    localparam int NPIX    = IMG_W * IMG_H;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    bist_start = 1'b0;
    logic [1:0]              mode = 2'd0;
    logic [PIX_W-1:0]        const_val = '0;
    logic [7:0]              num_frames = 8'd0;
    logic                    gap_en = 1'b0;
    logic signed [RES_W-1:0] expected = '0;
    logic                    start_signal;
    logic                    pixel_valid;
    logic [PIX_W-1:0]        pixel_in;
    logic                    final_result_valid;
    logic signed [RES_W-1:0] final_lane_result;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic [7:0]              frame_cnt;
    logic [7:0]              mismatch_cnt;
    logic                    err_timeout;
    logic                    err_spurious;
    logic signed [RES_W-1:0] last_result;
    state_t                  dbg_state;

    cnn_frame_bist dut (
        .clk                (clk),
        .rst                (rst),
        .bist_start         (bist_start),
        .mode               (mode),
        .const_val          (const_val),
        .num_frames         (num_frames),
        .gap_en             (gap_en),
        .expected           (expected),
        .start_signal       (start_signal),
        .pixel_valid        (pixel_valid),
        .pixel_in           (pixel_in),
        .final_result_valid (final_result_valid),
        .final_lane_result  (final_lane_result),
        .busy               (busy),
        .done               (done),
        .pass               (pass),
        .frame_cnt          (frame_cnt),
        .mismatch_cnt       (mismatch_cnt),
        .err_timeout        (err_timeout),
        .err_spurious       (err_spurious),
        .last_result        (last_result),
        .dbg_state          (dbg_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PIX_W-1:0] exp_q[$];

    // responder configuration (written by the stimulus process only)
    bit               cfg_resp_en = 1'b1;
    int               cfg_lat = 10;
    logic [RES_W-1:0] cfg_good = '0;
    int               cfg_bad_frame = -1;
    bit               cfg_spur = 1'b0;
    int               run_seq = 0;

    // responder / monitor state (written by the monitor process only)
    int               seen_run = 0;
    int               mon_beats = 0;
    int               run_beats = 0;
    int               resp_wait = 0;
    int               resp_frame = 0;
    bit               resp_pending = 1'b0;
    bit               spur_done = 1'b0;
    bit               prev_valid = 1'b0;
    logic [PIX_W-1:0] prev_pix = '0;
    logic [PIX_W-1:0] first3[3];

    typedef struct {
        logic [1:0]       mode;
        logic [7:0]       cval;
        logic [7:0]       nf;
        logic             gap;
        logic [RES_W-1:0] expd;
        logic [RES_W-1:0] good;
        int               bad;
        int               lat;
        logic [7:0]       exp_fc;
        logic [7:0]       exp_mis;
        logic             exp_pass;
        logic [RES_W-1:0] exp_last;
        logic [7:0]       f0;
        logic [7:0]       f1;
        logic [7:0]       f2;
    } run_t;

    run_t vec[5];

    task automatic check(input string nm, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [PIX_W-1:0] model_pix(input logic [1:0] md, input logic [PIX_W-1:0] cv,
                                                   input int idx, input logic [15:0] lf);
        int x;
        int y;
        x = idx % IMG_W;
        y = idx / IMG_W;
        case (md)
            2'd0:    return PIX_W'(idx % 256);
            2'd1:    return cv;
            2'd2:    return lf[PIX_W-1:0];
            default: return (((x ^ y) & 1) != 0) ? 8'hFF : 8'h00;
        endcase
    endfunction

    // CNN responder and pixel scoreboard, evaluated away from the active edge
    always @(negedge clk) begin
        logic [15:0]      lf;
        logic [PIX_W-1:0] e;
        if (!rst) begin
            final_result_valid = 1'b0;
            final_lane_result  = '0;
            exp_q.delete();
            mon_beats    = 0;
            resp_pending = 1'b0;
            prev_valid   = 1'b0;
        end else begin
            final_result_valid = 1'b0;
            if (start_signal) begin
                if (seen_run != run_seq) begin
                    seen_run   = run_seq;
                    resp_frame = 0;
                    run_beats  = 0;
                    spur_done  = 1'b0;
                end
                mon_beats    = 0;
                resp_pending = 1'b0;
                lf = 16'hACE1;
                for (int i = 0; i < NPIX; i++) begin
                    exp_q.push_back(model_pix(mode, const_val, i, lf));
                    lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
                end
            end
            if (resp_pending && cfg_resp_en) begin
                resp_wait++;
                if (resp_wait >= cfg_lat) begin
                    final_result_valid = 1'b1;
                    final_lane_result  = (resp_frame == cfg_bad_frame) ? (cfg_good ^ 48'h8000_0000_0000) : cfg_good;
                    resp_frame++;
                    resp_pending = 1'b0;
                end
            end
            if (pixel_valid) begin
                if (exp_q.size() == 0) begin
                    check("pixel_extra_beat", 48'd1, 48'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", RES_W'(pixel_in), RES_W'(e));
                end
                if (run_beats < 3) first3[run_beats] = pixel_in;
                run_beats++;
                mon_beats++;
                if (cfg_spur && !spur_done && mon_beats == 100) begin
                    final_result_valid = 1'b1;
                    final_lane_result  = 48'h0000_0000_0BAD;
                    spur_done = 1'b1;
                end
                if (mon_beats == NPIX) begin
                    resp_pending = 1'b1;
                    resp_wait    = 0;
                end
            end else if (prev_valid) begin
                check("pixel_hold", RES_W'(pixel_in), RES_W'(prev_pix));
            end
            prev_valid = pixel_valid;
            prev_pix   = pixel_in;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_start_signal"}, RES_W'(start_signal), '0);
        check({tag, "_pixel_valid"},  RES_W'(pixel_valid), '0);
        check({tag, "_pixel_in"},     RES_W'(pixel_in), '0);
        check({tag, "_busy"},         RES_W'(busy), '0);
        check({tag, "_done"},         RES_W'(done), '0);
        check({tag, "_pass"},         RES_W'(pass), '0);
        check({tag, "_frame_cnt"},    RES_W'(frame_cnt), '0);
        check({tag, "_mismatch_cnt"}, RES_W'(mismatch_cnt), '0);
        check({tag, "_err_timeout"},  RES_W'(err_timeout), '0);
        check({tag, "_err_spurious"}, RES_W'(err_spurious), '0);
        check({tag, "_last_result"},  last_result, '0);
        check({tag, "_state"},        RES_W'(dbg_state), RES_W'(IDLE));
    endtask

    task automatic apply_cfg(input run_t r);
        mode          = r.mode;
        const_val     = r.cval;
        num_frames    = r.nf;
        gap_en        = r.gap;
        expected      = r.expd;
        cfg_good      = r.good;
        cfg_bad_frame = r.bad;
        cfg_lat       = r.lat;
        cfg_resp_en   = 1'b1;
        cfg_spur      = 1'b0;
        run_seq++;
    endtask

    // Leaves the caller at the negedge of the first pixel beat
    task automatic start_pulse(input string tag);
        @(negedge clk);
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        check({tag, "_start_hi"}, RES_W'(start_signal), 48'd1);
        check({tag, "_busy_hi"},  RES_W'(busy), 48'd1);
        check({tag, "_done_clr"}, RES_W'(done), 48'd0);
        @(negedge clk);
        check({tag, "_first_beat"}, RES_W'(pixel_valid), 48'd1);
        check({tag, "_start_lo"},   RES_W'(start_signal), 48'd0);
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int c;
        c = 0;
        while (!done && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_done_reached"}, RES_W'(done), 48'd1);
    endtask

    task automatic run_vec(input run_t r, input string tag);
        apply_cfg(r);
        start_pulse(tag);
        wait_done(20000, tag);
        check({tag, "_busy"},         RES_W'(busy), 48'd0);
        check({tag, "_frame_cnt"},    RES_W'(frame_cnt), RES_W'(r.exp_fc));
        check({tag, "_mismatch_cnt"}, RES_W'(mismatch_cnt), RES_W'(r.exp_mis));
        check({tag, "_pass"},         RES_W'(pass), RES_W'(r.exp_pass));
        check({tag, "_err_timeout"},  RES_W'(err_timeout), 48'd0);
        check({tag, "_err_spurious"}, RES_W'(err_spurious), 48'd0);
        check({tag, "_last_result"},  last_result, r.exp_last);
        check({tag, "_px0"},          RES_W'(first3[0]), RES_W'(r.f0));
        check({tag, "_px1"},          RES_W'(first3[1]), RES_W'(r.f1));
        check({tag, "_px2"},          RES_W'(first3[2]), RES_W'(r.f2));
        check({tag, "_queue_empty"},  RES_W'(exp_q.size()), 48'd0);
    endtask

    initial begin
        int span;
        int run_len;
        int zeros;
        int n;

        // LFSR pixels follow the Galois step 0xACE1 -> 0xE270 -> 0x7138
        vec[0] = '{2'd0, 8'h00, 8'd1, 1'b0, 48'd1315356, 48'd1315356, -1, 20,
                   8'd1, 8'd0, 1'b1, 48'd1315356, 8'h00, 8'h01, 8'h02};
        vec[1] = '{2'd2, 8'h00, 8'd3, 1'b0, 48'h0000_1234_5678, 48'h0000_1234_5678, 1, 7,
                   8'd3, 8'd1, 1'b0, 48'h0000_1234_5678, 8'hE1, 8'h70, 8'h38};
        vec[2] = '{2'd1, 8'h5A, 8'd0, 1'b0, 48'hFFFF_FFFF_FFFB, 48'hFFFF_FFFF_FFFB, -1, 3,
                   8'd1, 8'd0, 1'b1, 48'hFFFF_FFFF_FFFB, 8'h5A, 8'h5A, 8'h5A};
        vec[3] = '{2'd3, 8'h00, 8'd2, 1'b1, 48'd777, 48'd777, -1, 5,
                   8'd2, 8'd0, 1'b1, 48'd777, 8'h00, 8'hFF, 8'h00};
        vec[4] = '{2'd0, 8'h00, 8'd2, 1'b0, 48'hFFFF_FFFF_FFFB, 48'hFFFF_FFFF_FFFB, 1, 4,
                   8'd2, 8'd1, 1'b0, 48'h7FFF_FFFF_FFFB, 8'h00, 8'h01, 8'h02};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(vec[i], $sformatf("v%0d", i));
        end

        // Row gaps: 1024 beats plus one idle cycle after every row, last row included
        apply_cfg(vec[3]);
        num_frames = 8'd1;
        start_pulse("gap");
        span = 1;
        run_len = 1;
        zeros = 0;
        while (span < 3000) begin
            @(negedge clk);
            if (dbg_state == WAIT_RES) break;
            span++;
            if (pixel_valid) begin
                run_len++;
            end else begin
                check("gap_row_len", RES_W'(run_len), 48'd32);
                run_len = 0;
                zeros++;
            end
        end
        check("gap_span", RES_W'(span), 48'd1056);
        check("gap_count", RES_W'(zeros), 48'd32);
        wait_done(200, "gap");
        check("gap_pass", RES_W'(pass), 48'd1);

        // No answer: timeout exactly TIMEOUT cycles after WAIT_RES entry
        apply_cfg(vec[0]);
        cfg_resp_en = 1'b0;
        start_pulse("to");
        n = 0;
        while (dbg_state != WAIT_RES && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("to_wait_entry", RES_W'(dbg_state), RES_W'(WAIT_RES));
        n = 0;
        while (!err_timeout && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", RES_W'(n), RES_W'(TIMEOUT));
        wait_done(10, "to");
        check("to_err_timeout",  RES_W'(err_timeout), 48'd1);
        check("to_mismatch_cnt", RES_W'(mismatch_cnt), 48'd1);
        check("to_frame_cnt",    RES_W'(frame_cnt), 48'd1);
        check("to_pass",         RES_W'(pass), 48'd0);

        // Spurious result during STREAM, plus a bist_start while busy that must be ignored
        apply_cfg(vec[0]);
        num_frames = 8'd2;
        cfg_spur = 1'b1;
        start_pulse("sp");
        repeat (200) @(negedge clk);
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        check("sp_busy_kept",     RES_W'(busy), 48'd1);
        check("sp_no_restart",    RES_W'(start_signal), 48'd0);
        check("sp_frame_cnt_mid", RES_W'(frame_cnt), 48'd0);
        check("sp_flag_mid",      RES_W'(err_spurious), 48'd1);
        wait_done(20000, "sp");
        check("sp_err_spurious", RES_W'(err_spurious), 48'd1);
        check("sp_mismatch_cnt", RES_W'(mismatch_cnt), 48'd0);
        check("sp_frame_cnt",    RES_W'(frame_cnt), 48'd2);
        check("sp_pass",         RES_W'(pass), 48'd0);
        check("sp_last_result",  last_result, 48'd1315356);
        check("sp_queue_empty",  RES_W'(exp_q.size()), 48'd0);
        cfg_spur = 1'b0;

        // Asynchronous reset in the middle of frame 1, then a clean run
        apply_cfg(vec[0]);
        start_pulse("mr");
        n = 0;
        while (mon_beats < 500 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mr_beats_reached", RES_W'(mon_beats), 48'd500);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(vec[0], "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
